// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Arbitrates one PTE fetch port between the IMMU and DMMU TLB reload walkers,
// holding ownership for a whole walk. Define MOR1KX_TLB_ARB_TIMEOUT_EN for a bus watchdog.
module mor1kx_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    output logic                            immu_err_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic                            dmmu_err_o,

    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
    input  logic                            bus_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_data_i,
    input  logic                            bus_err_i,

    output logic [1:0]                      grant_o,
    output logic                            busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DECIDE
    } state_t;

    state_t                            state_q;
    logic                              owner_dmmu_q;
    logic                              last_dmmu_q;
    logic                              abort_q;
    logic [1:0]                        grant_q;
    logic                              bus_req_q;
    logic [OPTION_OPERAND_WIDTH-1:0]   bus_addr_q;
    logic                              immu_ack_q;
    logic [OPTION_OPERAND_WIDTH-1:0]   immu_data_q;
    logic                              immu_err_q;
    logic                              dmmu_ack_q;
    logic [OPTION_OPERAND_WIDTH-1:0]   dmmu_data_q;
    logic                              dmmu_err_q;

    logic                              owner_req;
    logic [OPTION_OPERAND_WIDTH-1:0]   owner_addr;
    logic                              pick_dmmu;
    logic                              discard;
    logic                              timeout;
    logic                              rsp_err;
    logic [OPTION_OPERAND_WIDTH-1:0]   rsp_data;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign owner_req  = owner_dmmu_q ? dmmu_req_i  : immu_req_i;
    assign owner_addr = owner_dmmu_q ? dmmu_addr_i : immu_addr_i;
    // On a tie the walker that did not own the port last time wins.
    assign pick_dmmu  = dmmu_req_i & (~immu_req_i | ~last_dmmu_q);
    // A walker that let go of req at any point during the fetch gets no response.
    assign discard    = abort_q | ~owner_req;
    // A watchdog expiry without a bus ack is reported as an error with zero data.
    assign rsp_err    = bus_ack_i ? bus_err_i : 1'b1;
    assign rsp_data   = (bus_ack_i && !bus_err_i) ? bus_data_i : '0;

`ifdef MOR1KX_TLB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;

    assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_dmmu_q <= 1'b0;
            last_dmmu_q  <= 1'b0;
            abort_q      <= 1'b0;
            grant_q      <= 2'b00;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            immu_ack_q   <= 1'b0;
            immu_data_q  <= '0;
            immu_err_q   <= 1'b0;
            dmmu_ack_q   <= 1'b0;
            dmmu_data_q  <= '0;
            dmmu_err_q   <= 1'b0;
        end else begin
            immu_ack_q <= 1'b0;
            dmmu_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (immu_req_i || dmmu_req_i) begin
                        owner_dmmu_q <= pick_dmmu;
                        last_dmmu_q  <= pick_dmmu;
                        grant_q      <= pick_dmmu ? 2'b10 : 2'b01;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_addr_q <= owner_addr;
                    bus_req_q  <= 1'b1;
                    abort_q    <= ~owner_req;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (bus_ack_i || timeout) begin
                        bus_req_q <= 1'b0;
                        if (discard) begin
                            grant_q <= 2'b00;
                            state_q <= IDLE;
                        end else begin
                            state_q <= RESP;
                            if (owner_dmmu_q) begin
                                dmmu_ack_q  <= 1'b1;
                                dmmu_data_q <= rsp_data;
                                dmmu_err_q  <= rsp_err;
                            end else begin
                                immu_ack_q  <= 1'b1;
                                immu_data_q <= rsp_data;
                                immu_err_q  <= rsp_err;
                            end
                        end
                    end else begin
                        abort_q <= discard;
                    end
                end
                RESP: begin
                    state_q <= DECIDE;
                end
                DECIDE: begin
                    if (owner_req) begin
                        state_q <= ISSUE;
                    end else begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q   <= 2'b00;
                    bus_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign immu_ack_o  = immu_ack_q;
    assign immu_data_o = immu_data_q;
    assign immu_err_o  = immu_err_q;
    assign dmmu_ack_o  = dmmu_ack_q;
    assign dmmu_data_o = dmmu_data_q;
    assign dmmu_err_o  = dmmu_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Self-checking bench for mor1kx_tlb_reload_arbiter: directed walks plus randomized
// walk sequences checked against a transaction-level arbitration model.
module tb_mor1kx_tlb_reload_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         immu_req_i = 1'b0;
    logic [W-1:0] immu_addr_i = '0;
    logic         dmmu_req_i = 1'b0;
    logic [W-1:0] dmmu_addr_i = '0;
    logic         bus_ack_i = 1'b0;
    logic [W-1:0] bus_data_i = '0;
    logic         bus_err_i = 1'b0;

    logic         immu_ack_o, immu_err_o, dmmu_ack_o, dmmu_err_o;
    logic [W-1:0] immu_data_o, dmmu_data_o, bus_addr_o;
    logic         bus_req_o, busy_o;
    logic [1:0]   grant_o;

    int tests = 0;
    int fails = 0;

    // Reference model state: who owned the port last (0 = IMMU, 1 = DMMU) and
    // the word/error each walker should currently be seeing.
    int           m_last = 0;
    logic [W-1:0] m_data [2];
    logic         m_err  [2];

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .immu_req_i(immu_req_i), .immu_addr_i(immu_addr_i),
        .immu_ack_o(immu_ack_o), .immu_data_o(immu_data_o), .immu_err_o(immu_err_o),
        .dmmu_req_i(dmmu_req_i), .dmmu_addr_i(dmmu_addr_i),
        .dmmu_ack_o(dmmu_ack_o), .dmmu_data_o(dmmu_data_o), .dmmu_err_o(dmmu_err_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_ack_i(bus_ack_i), .bus_data_i(bus_data_i), .bus_err_i(bus_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] onehot(input int who);
        return (who == 1) ? W'(2) : W'(1);
    endfunction

    function automatic logic [W-1:0] acks();
        return W'({dmmu_ack_o, immu_ack_o});
    endfunction

    function automatic int model_pick();
        if (immu_req_i && dmmu_req_i) return (m_last == 1) ? 0 : 1;
        return dmmu_req_i ? 1 : 0;
    endfunction

    task automatic set_req(input int who, input logic v);
        if (who == 1) dmmu_req_i = v; else immu_req_i = v;
    endtask

    task automatic set_addr(input int who, input logic [W-1:0] a);
        if (who == 1) dmmu_addr_i = a; else immu_addr_i = a;
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_idata"}, immu_data_o, m_data[0]);
        chk({tag, "_ierr"},  W'(immu_err_o), W'(m_err[0]));
        chk({tag, "_ddata"}, dmmu_data_o, m_data[1]);
        chk({tag, "_derr"},  W'(dmmu_err_o), W'(m_err[1]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busreq"}, W'(bus_req_o), '0);
        chk({tag, "_busaddr"}, bus_addr_o, '0);
        chk({tag, "_grant"}, W'(grant_o), '0);
        chk({tag, "_busy"}, W'(busy_o), '0);
        chk({tag, "_acks"}, acks(), '0);
        chk_hold(tag);
    endtask

    // Called in an IDLE cycle with the requests already driven.
    task automatic begin_walk(input int who);
        tick();
        chk("grant_start", W'(grant_o), onehot(who));
        chk("busy_start", W'(busy_o), W'(1));
        chk("busreq_issue", W'(bus_req_o), '0);
        m_last = who;
    endtask

    // Called in the ISSUE cycle; k extra WAIT cycles before the bus acks.
    task automatic fetch(input int who, input logic [W-1:0] a, input logic [W-1:0] na,
                         input bit last, input int k, input logic [W-1:0] d, input logic e);
        tick();
        chk("busreq_wait", W'(bus_req_o), W'(1));
        chk("busaddr", bus_addr_o, a);
        chk("grant_wait", W'(grant_o), onehot(who));
        repeat (k) begin
            tick();
            chk("busreq_hold", W'(bus_req_o), W'(1));
            chk("busaddr_hold", bus_addr_o, a);
            chk("acks_wait", acks(), '0);
        end
        bus_ack_i  = 1'b1;
        bus_data_i = d;
        bus_err_i  = e;
        tick();
        bus_ack_i  = 1'b0;
        bus_data_i = $urandom;
        bus_err_i  = 1'($urandom_range(0, 1));
        m_data[who] = e ? '0 : d;
        m_err[who]  = e;
        chk("ack_pulse", acks(), onehot(who));
        chk("busreq_drop", W'(bus_req_o), '0);
        chk_hold("resp");
        if (last) set_req(who, 1'b0);
        else      set_addr(who, na);
        tick();
        chk("ack_single", acks(), '0);
        chk("busy_decide", W'(busy_o), W'(1));
        // A stray bus ack outside WAIT must be ignored.
        bus_ack_i = 1'($urandom_range(0, 1));
        tick();
        bus_ack_i = 1'b0;
        if (last) begin
            chk("grant_release", W'(grant_o), '0);
            chk("busy_release", W'(busy_o), '0);
        end else begin
            chk("grant_keep", W'(grant_o), onehot(who));
            chk("busreq_reissue", W'(bus_req_o), '0);
        end
        chk_hold("after");
    endtask

    task automatic rand_walk();
        int w;
        int nf;
        logic [W-1:0] a, na;
        w = model_pick();
        a = $urandom;
        set_addr(w, a);
        begin_walk(w);
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
            na = $urandom;
            fetch(w, a, na, (f == nf - 1), $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 3) == 0));
            a = na;
        end
    endtask

    initial begin
        int w;
        m_data[0] = '0; m_data[1] = '0;
        m_err[0]  = 1'b0; m_err[1] = 1'b0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", W'(busy_o), '0);

        // Both requests high from reset: DMMU first, then IMMU, then DMMU again
        immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r == 2) begin immu_req_i = 1'b1; dmmu_req_i = 1'b1; end
            w = model_pick();
            chk("rr_model", W'(w), W'((r % 2 == 0) ? 1 : 0));
            rand_walk();
        end

        // DMMU two-fetch walk while IMMU waits
        immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        dmmu_addr_i = 32'h0000_0100;
        w = model_pick();
        begin_walk(w);
        fetch(1, 32'h0000_0100, 32'h0000_2008, 1'b0, 2, $urandom, 1'b0);
        fetch(1, 32'h0000_2008, '0, 1'b1, 1, $urandom, 1'b0);
        rand_walk();

        // DMMU only, fixed address and data
        dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0000_1004;
        begin_walk(model_pick());
        fetch(1, 32'h0000_1004, '0, 1'b1, 1, 32'hA5A5_0400, 1'b0);

        // Bus error response
        immu_req_i = 1'b1; immu_addr_i = 32'h0000_3000;
        begin_walk(model_pick());
        fetch(0, 32'h0000_3000, '0, 1'b1, 0, 32'hDEAD_BEEF, 1'b1);

        // Abort: owner drops req during WAIT, bus acks 4 cycles later
        dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0000_4040;
        begin_walk(model_pick());
        tick();
        chk("abort_busreq", W'(bus_req_o), W'(1));
        dmmu_req_i = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_busreq_hold", W'(bus_req_o), W'(1));
            chk("abort_busy", W'(busy_o), W'(1));
            chk("abort_acks", acks(), '0);
        end
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        tick();
        bus_ack_i = 1'b0;
        chk("abort_noack", acks(), '0);
        chk("abort_busreq_drop", W'(bus_req_o), '0);
        chk("abort_idle", W'(busy_o), '0);
        chk("abort_grant", W'(grant_o), '0);
        chk_hold("abort");

        // Reset asserted during WAIT
        immu_req_i = 1'b1; immu_addr_i = 32'h0000_5000;
        begin_walk(model_pick());
        tick();
        chk("rstwait_busreq", W'(bus_req_o), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        m_last = 0;
        m_data[0] = '0; m_data[1] = '0;
        m_err[0]  = 1'b0; m_err[1] = 1'b0;
        chk_all_zero("async_reset");
        immu_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", W'(busy_o), '0);
        immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        chk("post_reset_pick", W'(model_pick()), W'(1));
        rand_walk();
        rand_walk();

        // Randomized walk sequences
        for (int it = 0; it < 30; it++) begin
            if (!immu_req_i && !dmmu_req_i) begin
                w = $urandom_range(1, 3);
                immu_req_i = w[0];
                dmmu_req_i = w[1];
            end else if ($urandom_range(0, 1) == 1) begin
                immu_req_i = 1'b1;
                dmmu_req_i = 1'b1;
            end
            rand_walk();
        end
        immu_req_i = 1'b0; dmmu_req_i = 1'b0;
        tick();
        chk("final_idle", W'(busy_o), '0);

`ifdef MOR1KX_TLB_ARB_TIMEOUT_EN
        // Watchdog: no bus ack, error response after TO WAIT cycles
        immu_req_i = 1'b1; immu_addr_i = 32'h0000_6000;
        begin_walk(model_pick());
        tick();
        repeat (TO - 1) begin
            tick();
            chk("to_busreq_hold", W'(bus_req_o), W'(1));
            chk("to_acks", acks(), '0);
        end
        tick();
        m_data[0] = '0; m_err[0] = 1'b1;
        chk("to_ack", acks(), W'(1));
        chk("to_busreq_drop", W'(bus_req_o), '0);
        chk_hold("to");
        immu_req_i = 1'b0;
        tick();
        tick();
        chk("to_idle", W'(busy_o), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
